// File: rtl/object_draw_arbiter.sv
// Fixed-priority per-pixel draw arbiter with per-frame overlap (collision) accumulation.
// Optional macro ARB_COLLISION_HIGHLIGHT_EN paints overlapping pixels with HIGHLIGHT_COLOR.
module object_draw_arbiter #(
  parameter int         NUM_REQ              = 4,
  parameter logic [7:0] TRANSPARENT_ENCODING = 8'hFF,
  parameter logic [7:0] HIGHLIGHT_COLOR      = 8'hE0
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic [NUM_REQ-1:0]         drawReq,
  input  logic [8*NUM_REQ-1:0]       rgbIn,
  input  logic [7:0]                 bgRGB,
  output logic [7:0]                 RGBout,
  output logic                       drawingRequest,
  output logic [$clog2(NUM_REQ)-1:0] winnerIdx,
  output logic [NUM_REQ-1:0]         collisionMask,
  output logic                       collisionValid,
  output logic [7:0]                 frameCount
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [0:0] WAIT_SOF = 1'b0;
  localparam logic [0:0] RUN      = 1'b1;

  logic [0:0]         state_r;
  logic [NUM_REQ-1:0] acc_r;

  logic [NUM_REQ-1:0] eff_s;
  logic [NUM_REQ-1:0] ov_s;
  logic [3:0]         cnt_s;
  logic               found_s;
  logic [IDX_W-1:0]   winner_s;
  logic [7:0]         win_rgb_s;
  logic [7:0]         rgb_next_s;

  function automatic logic [3:0] count_ones(input logic [NUM_REQ-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

  // Effective requests, priority winner (descending scan so index 0 ends up winning) and overlap vector.
  always_comb begin
    eff_s     = {NUM_REQ{1'b0}};
    found_s   = 1'b0;
    winner_s  = {IDX_W{1'b0}};
    win_rgb_s = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      eff_s[i] = drawReq[i] && (rgbIn[8*i +: 8] != TRANSPARENT_ENCODING);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eff_s[i]) begin
        found_s   = 1'b1;
        winner_s  = IDX_W'(i);
        win_rgb_s = rgbIn[8*i +: 8];
      end else begin
        found_s   = found_s;
      end
    end
    cnt_s = count_ones(eff_s);
    if (cnt_s >= 4'd2) begin
      ov_s = eff_s;
    end else begin
      ov_s = {NUM_REQ{1'b0}};
    end
  end

  // Pixel colour selection, including the optional collision highlight.
  always_comb begin
    rgb_next_s = bgRGB;
    if (found_s) begin
      rgb_next_s = win_rgb_s;
    end else begin
      rgb_next_s = bgRGB;
    end
`ifdef ARB_COLLISION_HIGHLIGHT_EN
    if (cnt_s >= 4'd2) begin
      rgb_next_s = HIGHLIGHT_COLOR;
    end else begin
      rgb_next_s = rgb_next_s;
    end
`endif
  end

  // Registered pixel path: one cycle of latency in every state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      RGBout         <= 8'h00;
      drawingRequest <= 1'b0;
      winnerIdx      <= {IDX_W{1'b0}};
    end else begin
      RGBout         <= rgb_next_s;
      drawingRequest <= found_s;
      winnerIdx      <= winner_s;
    end
  end

  // Frame tracking: the first SOF after reset only arms accumulation; later SOFs publish the old frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r        <= WAIT_SOF;
      acc_r          <= {NUM_REQ{1'b0}};
      collisionMask  <= {NUM_REQ{1'b0}};
      collisionValid <= 1'b0;
      frameCount     <= 8'd0;
    end else begin
      collisionValid <= 1'b0;
      case (state_r)
        WAIT_SOF: begin
          if (startOfFrame) begin
            acc_r   <= ov_s;
            state_r <= RUN;
          end else begin
            acc_r   <= {NUM_REQ{1'b0}};
          end
        end
        RUN: begin
          if (startOfFrame) begin
            collisionMask  <= acc_r;
            collisionValid <= 1'b1;
            frameCount     <= frameCount + 8'd1;
            acc_r          <= ov_s;
          end else begin
            acc_r          <= acc_r | ov_s;
          end
        end
        default: begin
          state_r <= WAIT_SOF;
          acc_r   <= {NUM_REQ{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_object_draw_arbiter.sv
// Scoreboard bench for object_draw_arbiter: a frame-level reference model pushes expectations, a monitor compares.
module tb_object_draw_arbiter;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic [3:0]  drawReq;
  logic [31:0] rgbIn;
  logic [7:0]  bgRGB;
  logic [7:0]  RGBout;
  logic        drawingRequest;
  logic [1:0]  winnerIdx;
  logic [3:0]  collisionMask;
  logic        collisionValid;
  logic [7:0]  frameCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] rgb;
    logic       dreq;
    logic [1:0] idx;
    logic [3:0] cmask;
    logic       cvalid;
    logic [7:0] fcount;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state, expressed as per-frame facts.
  bit       m_started;
  bit       m_seen[4];
  bit [3:0] m_published;
  int       m_frames;

  object_draw_arbiter #(.NUM_REQ(4)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .drawReq(drawReq),
    .rgbIn(rgbIn), .bgRGB(bgRGB), .RGBout(RGBout), .drawingRequest(drawingRequest),
    .winnerIdx(winnerIdx), .collisionMask(collisionMask), .collisionValid(collisionValid),
    .frameCount(frameCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_started   = 0;
    m_published = 4'b0000;
    m_frames    = 0;
    for (int i = 0; i < 4; i++) m_seen[i] = 0;
  endtask

  function automatic exp_t model_step(input bit sof, input logic [3:0] req,
                                      input logic [31:0] rgb, input logic [7:0] bg);
    exp_t e;
    int   drawn[$];
    bit   over;
    for (int i = 0; i < 4; i++)
      if (req[i] && rgb[8*i +: 8] != 8'hFF) drawn.push_back(i);
    over = (drawn.size() > 1);
    if (drawn.size() > 0) begin
      e.rgb  = rgb[8*drawn[0] +: 8];
      e.dreq = 1'b1;
      e.idx  = 2'(drawn[0]);
    end else begin
      e.rgb  = bg;
      e.dreq = 1'b0;
      e.idx  = 2'd0;
    end
`ifdef ARB_COLLISION_HIGHLIGHT_EN
    if (over) e.rgb = 8'hE0;
`endif
    e.cvalid = 1'b0;
    if (sof) begin
      if (m_started) begin
        for (int i = 0; i < 4; i++) m_published[i] = m_seen[i];
        m_frames = (m_frames + 1) % 256;
        e.cvalid = 1'b1;
      end
      for (int i = 0; i < 4; i++) m_seen[i] = 0;
      m_started = 1;
    end
    if (m_started && over)
      foreach (drawn[k]) m_seen[drawn[k]] = 1;
    e.cmask  = m_published;
    e.fcount = 8'(m_frames);
    return e;
  endfunction

  task automatic drive(input bit sof, input logic [3:0] req, input logic [31:0] rgb, input logic [7:0] bg);
    startOfFrame = sof;
    drawReq      = req;
    rgbIn        = rgb;
    bgRGB        = bg;
    exp_q.push_back(model_step(sof, req, rgb, bg));
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"}, RGBout, 8'h00);
    check({tag, "_dreq"}, drawingRequest, 1'b0);
    check({tag, "_idx"}, winnerIdx, 2'd0);
    check({tag, "_cmask"}, collisionMask, 4'b0000);
    check({tag, "_cvalid"}, collisionValid, 1'b0);
    check({tag, "_fcount"}, frameCount, 8'd0);
  endtask

  // Monitor: outputs are presented every cycle, so one expectation is retired after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (resetN && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rgb", RGBout, e.rgb);
        check("dreq", drawingRequest, e.dreq);
        check("idx", winnerIdx, e.idx);
        check("cmask", collisionMask, e.cmask);
        check("cvalid", collisionValid, e.cvalid);
        check("fcount", frameCount, e.fcount);
      end
    end
  end

  initial begin
    logic [31:0] rgb;
    logic [3:0]  req;
    bit          sof;
    resetN = 1'b0; startOfFrame = 1'b0; drawReq = 4'b0000; rgbIn = 32'h0; bgRGB = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    resetN = 1'b1;
    @(posedge clk);
    #2;

    drive(1'b0, 4'b0000, 32'h0, 8'h12);
    check("tp_bg_rgb", RGBout, 8'h12);
    check("tp_bg_dreq", drawingRequest, 1'b0);
    drive(1'b0, 4'b1010, 32'h30_00_5B_00, 8'h12);
    check("tp_pri_rgb", RGBout, 8'h5B);
    check("tp_pri_idx", winnerIdx, 2'd1);
    drive(1'b0, 4'b0011, 32'h00_00_40_FF, 8'h12);
    check("tp_transp_rgb", RGBout, 8'h40);
    check("tp_transp_idx", winnerIdx, 2'd1);
    drive(1'b0, 4'b0110, 32'h00_22_11_00, 8'h12);
`ifdef ARB_COLLISION_HIGHLIGHT_EN
    check("tp_highlight_rgb", RGBout, 8'hE0);
`else
    check("tp_highlight_rgb", RGBout, 8'h11);
`endif

    // Collision sequence: arm, overlap 0 and 2 for three pixels, publish, then an empty frame.
    drive(1'b1, 4'b0000, 32'h0, 8'h12);
    repeat (3) drive(1'b0, 4'b0101, 32'h00_44_00_33, 8'h12);
    drive(1'b1, 4'b0000, 32'h0, 8'h12);
    check("tp_coll_mask", collisionMask, 4'b0101);
    check("tp_coll_valid", collisionValid, 1'b1);
    check("tp_coll_fc", frameCount, 8'd1);
    drive(1'b0, 4'b0001, 32'h00_00_00_33, 8'h12);
    check("tp_coll_hold", collisionMask, 4'b0101);
    drive(1'b1, 4'b0000, 32'h0, 8'h12);
    check("tp_coll_empty", collisionMask, 4'b0000);
    check("tp_coll_fc2", frameCount, 8'd2);

    // Back-to-back SOFs: the second publishes only the SOF pixel's own overlap.
    drive(1'b1, 4'b1100, 32'h55_66_00_00, 8'h12);
    drive(1'b1, 4'b0000, 32'h0, 8'h12);
    check("tp_b2b_mask", collisionMask, 4'b1100);

    // Mid-frame reset after overlaps: next SOF only arms, following SOF publishes post-reset overlap.
    drive(1'b0, 4'b0011, 32'h00_00_01_02, 8'h12);
    #1 resetN = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midreset");
    #1 resetN = 1'b1;
    @(posedge clk);
    #2;
    drive(1'b1, 4'b0000, 32'h0, 8'h12);
    check("tp_rst_valid", collisionValid, 1'b0);
    check("tp_rst_fc", frameCount, 8'd0);
    drive(1'b0, 4'b1001, 32'h07_00_00_08, 8'h12);
    drive(1'b1, 4'b0000, 32'h0, 8'h12);
    check("tp_rst_mask", collisionMask, 4'b1001);

    // Randomized pixels with sparse frame starts.
    for (int n = 0; n < 400; n++) begin
      req = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++)
        rgb[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      sof = ($urandom_range(0, 24) == 0);
      drive(sof, req, rgb, 8'($urandom_range(0, 255)));
    end

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/object_draw_arbiter.md
Name: object_draw_arbiter

Overview:
- Per-pixel arbiter for the VGA draw path. It takes NUM_REQ object drawing requests and colours (tanks, bullets, bricks, frame objects) and picks one winner by fixed priority.
- Outputs a registered RGB/drawingRequest pair to the VGA output stage.
- Also accumulates inter-object overlap (collision) flags over each frame. It publishes them once per frame, at startOfFrame, for the game-logic controllers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); index 0 = highest priority.
- TRANSPARENT_ENCODING, 8'hFF, colour value treated as "not drawn" even when the request is high.
- HIGHLIGHT_COLOR, 8'hE0, collision highlight colour (used only with the optional feature).

Ports:
- clk, in, 1, system clock.
- resetN, in, 1, asynchronous, active-low reset.
- startOfFrame, in, 1, single-cycle pulse on the first pixel of each frame.
- drawReq, in, NUM_REQ, per-requester drawing request for the current pixel.
- rgbIn, in, 8*NUM_REQ, requester i colour on bits [8i+7:8i].
- bgRGB, in, 8, background colour when no requester wins.
- RGBout, out, 8, registered pixel colour.
- drawingRequest, out, 1, registered: some requester won this pixel.
- winnerIdx, out, clog2(NUM_REQ), registered index of the winner (0 when none).
- collisionMask, out, NUM_REQ, bit i set if requester i overlapped any other requester during the last complete frame.
- collisionValid, out, 1, one-cycle pulse when collisionMask is updated.
- frameCount, out, 8, completed-frame counter.

Behaviour:
- Reset values:
  - RGBout=8'h00, drawingRequest=0, winnerIdx=0.
  - collisionMask=0, collisionValid=0, frameCount=0.
  - Internal accumulator=0; state=WAIT_SOF.
- Effective request: eff[i] = drawReq[i] && (rgbIn[i] != TRANSPARENT_ENCODING).
- Arbitration:
  - Winner = lowest i with eff[i]=1.
  - RGBout <= rgbIn[winner], drawingRequest <= 1, winnerIdx <= winner.
  - If no eff bit is set: RGBout <= bgRGB, drawingRequest <= 0, winnerIdx <= 0.
- Latency: exactly 1 clk from inputs to RGBout/drawingRequest/winnerIdx. This holds in every state; no pixel is ever dropped.
- Overlap per cycle: ov[i] = eff[i] && (count of eff bits >= 2).
- State machine:
  - WAIT_SOF: arbitration active; accumulator held at 0; no collisionValid.
    - On startOfFrame: accumulator <= ov, go to RUN. No collisionValid and no frameCount increment on this first pulse.
  - RUN, startOfFrame=0: accumulator <= accumulator | ov.
  - RUN, startOfFrame=1:
    - collisionMask <= accumulator, i.e. the old frame only, excluding the current cycle.
    - collisionValid <= 1 for one cycle.
    - frameCount <= frameCount+1, wrapping 255->0.
    - accumulator <= ov, so the current pixel starts the new frame.
- collisionMask holds its value between updates.
- startOfFrame pulses on consecutive cycles are each honoured: each publishes, and the second publishes the single-cycle accumulation.
- Asynchronous reset mid-frame: all outputs and state return to reset values immediately. Operation resumes in WAIT_SOF, so a partial frame is never published.
- All requester bits high with the same colour still counts as overlap; colour equality is irrelevant.

Optional Feature:
- Macro ARB_COLLISION_HIGHLIGHT_EN.
- Defined: when the count of eff bits >= 2 in a cycle, RGBout <= HIGHLIGHT_COLOR instead of the winner colour. drawingRequest and winnerIdx are unchanged.
- Undefined: no highlight; RGBout always follows the arbitration rule. The HIGHLIGHT_COLOR parameter is unused.

Test Plan:
- Reset, then drawReq=4'b0000, bgRGB=8'h12 -> next cycle RGBout=8'h12, drawingRequest=0, winnerIdx=0.
- drawReq=4'b1010, rgbIn[1]=8'h5B, rgbIn[3]=8'h30 -> next cycle RGBout=8'h5B, winnerIdx=1, drawingRequest=1.
- drawReq=4'b0011, rgbIn[0]=8'hFF, rgbIn[1]=8'h40 -> RGBout=8'h40, winnerIdx=1. No overlap is recorded because requester 0 is transparent.
- Collision sequence:
  - First SOF, then 3 cycles with drawReq=4'b0101 (opaque), then second SOF.
  - -> collisionValid pulses once, collisionMask=4'b0101, frameCount=1.
  - A third SOF with no overlap in between -> collisionMask=4'b0000, frameCount=2.
- Reset mid-frame after overlaps, then one SOF -> collisionValid stays 0, collisionMask=0, frameCount=0. The next SOF publishes only post-reset overlaps.
- With ARB_COLLISION_HIGHLIGHT_EN: drawReq=4'b0110, both opaque -> RGBout=8'hE0, winnerIdx=1. Without the macro -> RGBout=rgbIn[1].
